wb_imem_loader: RTL

- Wishbone classic responder in the user project area that drives port 0 (read/write) of the 32x512 instruction SRAM.
- Lets the management SoC load and read back core program memory over Wishbone instead of logic-analyzer pins.
- Holds a control register that keeps the RISC-V core in reset while loading; the core keeps fetching through SRAM port 1.

---
 rtl/wb_imem_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/wb_imem_loader.sv
// wb_imem_loader: Wishbone responder that loads and reads back the 32x512 instruction SRAM
// through port 0, with a control register that holds the core in reset while loading.
`default_nettype none

module wb_imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter logic [31:0] ID_VALUE  = 32'h1A0D_0001,
   parameter int          ADDR_W    = 9
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   output logic              csb0_o,
   output logic              web0_o,
   output logic [3:0]        wmask0_o,
   output logic [ADDR_W-1:0] addr0_o,
   output logic [31:0]       din0_o,
   input  logic [31:0]       dout0_i,
   output logic              core_reset_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RDWAIT = 2'd2,
      S_ACK    = 2'd3
   } state_t;

   state_t              state_q;
   logic                core_rst_q;
   logic                load_en_q;
   logic [15:0]         wcount_q;
   logic                we_q;
   logic                ack_q;
   logic [31:0]         dat_q;
   logic                csb0_q;
   logic                web0_q;
   logic [3:0]          wmask0_q;
   logic [ADDR_W-1:0]   addr0_q;
   logic [31:0]         din0_q;

   logic                w_hit;
   logic                w_req;
   logic                w_is_csr;
   logic [8:0]          w_csr_idx;
   logic [31:0]         w_csr_rdata;
   logic                w_unused_ok;

   assign w_hit       = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
   assign w_req       = wbs_cyc_i & wbs_stb_i & w_hit;
   assign w_is_csr    = wbs_adr_i[11];
   assign w_csr_idx   = wbs_adr_i[10:2];
   assign w_unused_ok = &{1'b0, wbs_adr_i[1:0]};

   always_comb begin
      w_csr_rdata = 32'h0;
      case (w_csr_idx)
         9'd0:    w_csr_rdata = {30'h0, load_en_q, core_rst_q};
         9'd1:    w_csr_rdata = {16'h0, wcount_q};
         9'd2:    w_csr_rdata = ID_VALUE;
         default: w_csr_rdata = 32'h0;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q    <= S_IDLE;
         core_rst_q <= 1'b1;
         load_en_q  <= 1'b0;
         wcount_q   <= 16'h0;
         we_q       <= 1'b0;
         ack_q      <= 1'b0;
         dat_q      <= 32'h0;
         csb0_q     <= 1'b1;
         web0_q     <= 1'b1;
         wmask0_q   <= 4'h0;
         addr0_q    <= '0;
         din0_q     <= 32'h0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (w_req) begin
                  if (w_is_csr) begin
                     state_q <= S_ACK;
                     ack_q   <= 1'b1;
                     if (wbs_we_i) begin
                        dat_q <= 32'h0;
                        if (w_csr_idx == 9'd0) begin
                           core_rst_q <= wbs_dat_i[0];
                           load_en_q  <= wbs_dat_i[1];
                        end
                     end else begin
                        dat_q <= w_csr_rdata;
                     end
                  end else begin
                     // A write while load_en is clear is dropped here but still acked later.
                     state_q  <= S_ACCESS;
                     we_q     <= wbs_we_i;
                     csb0_q   <= wbs_we_i & ~load_en_q;
                     web0_q   <= ~(wbs_we_i & load_en_q);
                     wmask0_q <= wbs_sel_i;
                     addr0_q  <= wbs_adr_i[ADDR_W+1:2];
                     din0_q   <= wbs_dat_i;
                  end
               end
            end
            S_ACCESS: begin
               csb0_q   <= 1'b1;
               web0_q   <= 1'b1;
               wmask0_q <= 4'h0;
               addr0_q  <= '0;
               din0_q   <= 32'h0;
               if (!csb0_q && !web0_q) begin
                  wcount_q <= wcount_q + 16'd1;
               end
               if (!wbs_cyc_i) begin
                  state_q <= S_IDLE;
               end else if (we_q) begin
                  state_q <= S_ACK;
                  ack_q   <= 1'b1;
                  dat_q   <= 32'h0;
               end else begin
                  state_q <= S_RDWAIT;
               end
            end
            S_RDWAIT: begin
               if (!wbs_cyc_i) begin
                  state_q <= S_IDLE;
               end else begin
                  state_q <= S_ACK;
                  ack_q   <= 1'b1;
                  dat_q   <= dout0_i;
               end
            end
            S_ACK: begin
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wbs_ack_o    = ack_q;
   assign wbs_dat_o    = dat_q;
   assign csb0_o       = csb0_q;
   assign web0_o       = web0_q;
   assign wmask0_o     = wmask0_q;
   assign addr0_o      = addr0_q;
   assign din0_o       = din0_q;
   assign core_reset_o = core_rst_q;

endmodule

`default_nettype wire
